// File: rtl/router_port_arbiter.sv
// Output-port arbiter for a router: round-robin among requesters feeding one registered output beat.
// Define ARB_PKT_LOCK_EN to hold the grant on one requester until it sends req_last.
module router_port_arbiter #(
  parameter int unsigned n_req      = 5,
  parameter int unsigned data_width = 128,
  parameter int unsigned net_width  = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [n_req-1:0]                        req_valid,
  input  logic [n_req-1:0]                        req_last,
  input  logic [n_req*(data_width+net_width)-1:0] req_data,
  output logic [n_req-1:0]                        req_ready,
  output logic                                    out_valid,
  output logic                                    out_last,
  output logic [data_width+net_width-1:0]         out_data,
  input  logic                                    out_ready,
  output logic [$clog2(n_req)-1:0]                grant_id,
  output logic [15:0]                             pkt_count
);

  localparam int unsigned StreamWidth = data_width + net_width;
  localparam int unsigned IdWidth     = $clog2(n_req);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                   state_q, state_d;
  logic [IdWidth-1:0]       ptr_q, ptr_d;
  logic [IdWidth-1:0]       lock_id_q, lock_id_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [StreamWidth-1:0]   out_data_q, out_data_d;
  logic [IdWidth-1:0]       grant_id_q, grant_id_d;
  logic [15:0]              pkt_count_q, pkt_count_d;

  logic [IdWidth-1:0]       win_id, sel_id, cand;
  logic                     win_found, sel_valid, can_load, xfer;
  int unsigned              idx;

  // First valid requester scanning upward from ptr, wrapping at n_req-1.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < n_req; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= n_req) idx = idx - n_req;
      cand = IdWidth'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_id_d   = lock_id_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    grant_id_d  = grant_id_q;
    pkt_count_d = pkt_count_q;
    req_ready   = '0;

    can_load = ~out_valid_q | out_ready;
    if (state_q == StLocked) begin
      sel_id    = lock_id_q;
      sel_valid = req_valid[lock_id_q];
    end else begin
      sel_id    = win_id;
      sel_valid = win_found;
    end
    xfer = rst_n & sel_valid & can_load;

    if (xfer) begin
      req_ready[sel_id] = 1'b1;
      out_valid_d       = 1'b1;
      out_last_d        = req_last[sel_id];
      out_data_d        = req_data[32'(sel_id) * StreamWidth +: StreamWidth];
      grant_id_d        = sel_id;
      if (req_last[sel_id] && pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
      if (state_q == StIdle) begin
        ptr_d = (32'(sel_id) == n_req - 1) ? '0 : sel_id + IdWidth'(1);
      end
`ifdef ARB_PKT_LOCK_EN
      if (state_q == StIdle && !req_last[sel_id]) begin
        state_d   = StLocked;
        lock_id_d = sel_id;
      end else if (state_q == StLocked && req_last[sel_id]) begin
        state_d = StIdle;
      end
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      lock_id_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      grant_id_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_id_q   <= lock_id_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      grant_id_q  <= grant_id_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_id_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Bench for router_port_arbiter: packet-level reference model checked every cycle plus directed literals.
// Works with or without ARB_PKT_LOCK_EN defined.
module tb_router_port_arbiter;

  localparam int N  = 5;
  localparam int SW = 132;
  localparam int RR[5] = '{0, 2, 4, 0, 2};
`ifdef ARB_PKT_LOCK_EN
  localparam int         LK[4]  = '{1, 1, 1, 3};
  localparam logic [4:0] LK_RDY = 5'b00010;
  localparam int         LK_CNT = 8;
`else
  localparam int         LK[4]  = '{1, 3, 1, 3};
  localparam logic [4:0] LK_RDY = 5'b01000;
  localparam int         LK_CNT = 9;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '1;
  logic [N*SW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          out_valid, out_last;
  logic [SW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic [2:0]    grant_id;
  logic [15:0]   pkt_count;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned beat = 0;

  always #5 clk = ~clk;

  router_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .pkt_count (pkt_count)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester i carries {net=i, zeros, beat tag}; the tag changes every cycle.
  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*SW +: SW] = {4'(i), 96'h0, beat};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    beat++;
    drive_data();
  endtask

  // Reference model: an owner of -1 means no packet currently holds the port.
  int            m_ptr = 0;
  int            m_owner = -1;
  int            m_gid = 0;
  int            m_cnt = 0;
  logic          m_valid = 1'b0;
  logic          m_last = 1'b0;
  logic [SW-1:0] m_data = '0;

  function automatic int m_grant();
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g = m_grant();
    m_ready = '0;
    if (rst_n && g >= 0 && (!m_valid || out_ready)) m_ready[g] = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    int   g;
    logic take;
    if (!rst_n) begin
      m_ptr = 0; m_owner = -1; m_gid = 0; m_cnt = 0;
      m_valid = 1'b0; m_last = 1'b0; m_data = '0;
    end else begin
      g    = m_grant();
      take = (g >= 0) && (!m_valid || out_ready);
      if (take) begin
        m_data  = req_data[g*SW +: SW];
        m_last  = req_last[g];
        m_gid   = g;
        m_valid = 1'b1;
        if (req_last[g] && m_cnt < 65535) m_cnt++;
        if (m_owner < 0) m_ptr = (g + 1) % N;
`ifdef ARB_PKT_LOCK_EN
        if (m_owner < 0 && !req_last[g]) m_owner = g;
        else if (m_owner >= 0 && req_last[g]) m_owner = -1;
`endif
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", 160'(out_valid), 160'(m_valid));
    check("out_data", 160'(out_data), 160'(m_data));
    check("out_last", 160'(out_last), 160'(m_last));
    check("grant_id", 160'(grant_id), 160'(m_gid));
    check("pkt_count", 160'(pkt_count), 160'(m_cnt));
    check("req_ready", 160'(req_ready), 160'(m_ready()));
  end

  initial begin
    int exp_b;
    req_valid = '1;
    drive_data();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 160'(req_ready), 160'(0));
    check("rst_out_valid", 160'(out_valid), 160'(0));
    check("rst_pkt_count", 160'(pkt_count), 160'(0));

    req_valid = 5'b10101;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_gid", 160'(grant_id), 160'(RR[i]));
    end
    check("rr_cnt", 160'(pkt_count), 160'(5));
    req_valid = '0;
    step();
    check("drain_valid", 160'(out_valid), 160'(0));

    // Move ptr to 1, then a 3-beat packet from requester 1 competing with requester 3.
    req_valid = 5'b00001;
    step();
    check("pre_lock_gid", 160'(grant_id), 160'(0));
    req_valid = 5'b01010;
    req_last  = 5'b11101;
    step();
    check("lock_gid0", 160'(grant_id), 160'(LK[0]));
    #1;
    check("lock_ready", 160'(req_ready), 160'(LK_RDY));
    step();
    check("lock_gid1", 160'(grant_id), 160'(LK[1]));
    req_last = '1;
    step();
    check("lock_gid2", 160'(grant_id), 160'(LK[2]));
    req_valid = 5'b01000;
    step();
    check("lock_gid3", 160'(grant_id), 160'(LK[3]));
    check("lock_cnt", 160'(pkt_count), 160'(LK_CNT));

    req_valid = '1;
    step();
    check("bp_gid", 160'(grant_id), 160'(4));
    exp_b = int'(beat) - 1;
    out_ready = 1'b0;
    #1;
    check("bp_ready0", 160'(req_ready), 160'(0));
    repeat (4) begin
      step();
      check("bp_valid", 160'(out_valid), 160'(1));
      check("bp_data", 160'(out_data), 160'({4'd4, 96'h0, 32'(exp_b)}));
      check("bp_gid_hold", 160'(grant_id), 160'(4));
      check("bp_ready", 160'(req_ready), 160'(0));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("resume_gid", 160'(grant_id), 160'(i));
      check("resume_valid", 160'(out_valid), 160'(1));
    end

    req_valid = 5'b00100;
    req_last  = 5'b11011;
    step();
    check("mid_gid0", 160'(grant_id), 160'(2));
    req_valid = 5'b00101;
    step();
`ifdef ARB_PKT_LOCK_EN
    check("mid_gid1", 160'(grant_id), 160'(2));
`endif
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 160'(req_ready), 160'(0));
    check("mid_rst_valid", 160'(out_valid), 160'(0));
    check("mid_rst_cnt", 160'(pkt_count), 160'(0));
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_gid", 160'(grant_id), 160'(0));
    check("post_rst_valid", 160'(out_valid), 160'(1));

    req_valid = 5'b00001;
    req_last  = '1;
    repeat (65536) step();
    check("sat_cnt", 160'(pkt_count), 160'(16'hFFFF));
    repeat (3) step();
    check("sat_hold", 160'(pkt_count), 160'(16'hFFFF));
    check("sat_gid", 160'(grant_id), 160'(0));

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
